// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: owns the fetch PC and issues sequential instruction-memory
// requests over a valid/ready handshake. In-order responses are buffered,
// tagged with their PC, in a DEPTH-entry queue that feeds decode. A redirect
// flushes the queue and discards the responses still owed by memory.
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-low reset
//   pc_en               : fetch enable (responses and pops continue when 0)
//   redirect_valid/_pc  : branch/jump redirect strobe and target
//   imem_req_*          : request channel (valid/ready, addr = pc_reg)
//   imem_rsp_*          : in-order response channel (valid, 32-bit data)
//   inst_*              : head-of-queue instruction to decode (valid/ready)
//   pc_reg              : next fetch PC
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic [XLEN-1:0] pc_reg
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  logic [XLEN-1:0] pc_q;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   drop_cnt;

  logic [XLEN-1:0] ent_pc   [DEPTH];
  logic [31:0]     ent_data [DEPTH];
  logic [DEPTH-1:0] ent_filled;

  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   fill_idx;
  logic [IW-1:0]   rd_idx;

  logic [PW-1:0]   count_c;
  logic [PW-1:0]   pending_c;
  logic [PW-1:0]   drop_nxt_c;
  logic            req_valid_c;
  logic            req_fire_c;
  logic            rsp_drop_c;
  logic            rsp_fill_c;
  logic            inst_valid_c;
  logic            pop_c;

  assign wr_idx   = wr_ptr[IW-1:0];
  assign fill_idx = fill_ptr[IW-1:0];
  assign rd_idx   = rd_ptr[IW-1:0];

  // Handshake decode from registered state and the current-cycle strobes.
  always_comb begin
    count_c      = wr_ptr - rd_ptr;
    pending_c    = wr_ptr - fill_ptr;
    req_valid_c  = pc_en & (count_c < PW'(DEPTH)) & ~redirect_valid & (drop_cnt == '0);
    req_fire_c   = req_valid_c & imem_req_ready;
    rsp_drop_c   = imem_rsp_valid & (drop_cnt != '0);
    rsp_fill_c   = imem_rsp_valid & (drop_cnt == '0) & (pending_c != '0);
    inst_valid_c = ent_filled[rd_idx] & (count_c != '0) & ~redirect_valid;
    pop_c        = inst_valid_c & inst_ready;
    // Responses still owed by memory after a flush, net of one landing now.
    drop_nxt_c   = pending_c + drop_cnt - PW'(rsp_fill_c) - PW'(rsp_drop_c);
  end

  // Request is forced low while reset is held, independent of pc_en.
  assign imem_req_valid = req_valid_c & reset;
  assign imem_req_addr  = pc_q;
  assign pc_reg         = pc_q;
  assign inst_valid     = inst_valid_c;
  assign inst_data      = ent_data[rd_idx];
  assign inst_pc        = ent_pc[rd_idx];

  // PC, pointers, drop counter and queue storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      wr_ptr     <= '0;
      fill_ptr   <= '0;
      rd_ptr     <= '0;
      drop_cnt   <= '0;
      ent_filled <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent_pc[i]   <= '0;
        ent_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Redirect wins over any request, fill or pop in the same cycle.
      pc_q       <= redirect_pc & ~XLEN'(3);
      wr_ptr     <= '0;
      fill_ptr   <= '0;
      rd_ptr     <= '0;
      drop_cnt   <= drop_nxt_c;
      ent_filled <= '0;
    end else begin
      if (req_fire_c) begin
        ent_pc[wr_idx]     <= pc_q;
        ent_filled[wr_idx] <= 1'b0;
        wr_ptr             <= wr_ptr + PW'(1);
        pc_q               <= pc_q + XLEN'(4);
      end
      if (rsp_drop_c) begin
        drop_cnt <= drop_cnt - PW'(1);
      end
      // fill_idx never equals wr_idx when a fill and an allocate coincide:
      // that would need pending == DEPTH, which blocks the request.
      if (rsp_fill_c) begin
        ent_data[fill_idx]   <= imem_rsp_data;
        ent_filled[fill_idx] <= 1'b1;
        fill_ptr             <= fill_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed scenarios plus a randomized run checked
// against a queue-based reference model of the fetch queue.
module tb_fetch_queue_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic        clk_tb = 1'b0;
  logic        reset;
  logic        pc_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [31:0] pc_reg;

  int errors = 0;
  int checks = 0;

  // Addresses accepted by the memory and not yet answered.
  logic [31:0] mem_q[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          filled;
  } ent_t;

  fetch_queue_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk_tb), .reset(reset), .pc_en(pc_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .pc_reg(pc_reg)
  );

  always #5 clk_tb = ~clk_tb;

  // Memory side: record every accepted request (inputs are stable here).
  always @(negedge clk_tb) begin
    if (reset && imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'h0000_2231 + (a >> 2);
  endfunction

  task automatic drive_mem(input bit en, input bit rnd);
    logic [31:0] a;
    if (en && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = rnd ? 32'($urandom()) : mem_data(a);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; pc_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    mem_q.delete();
    repeat (2) @(posedge clk_tb);
    @(negedge clk_tb);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_tb); #1;
      pc_en = (c < 3); imem_req_ready = 1'b1; inst_ready = 1'b0; drive_mem(1'b1, 1'b0);
      @(negedge clk_tb);
    end
    checks++;
    if (pc_reg !== 32'hC || inst_valid !== 1'b1) begin
      errors++; $display("FAIL reset_prefill: pc_reg=%h inst_valid=%b, expected pc_reg=0000000c inst_valid=1", pc_reg, inst_valid);
    end
    #2;
    reset = 1'b0; pc_en = 1'b1; imem_rsp_valid = 1'b0;
    #1;
    checks++;
    if (pc_reg !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h, expected 00000000", pc_reg); end
    checks++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valids: req_valid=%b inst_valid=%b, expected 0 0", imem_req_valid, inst_valid);
    end
    checks++;
    if (dut.wr_ptr !== 3'd0 || dut.rd_ptr !== 3'd0 || dut.fill_ptr !== 3'd0 || dut.drop_cnt !== 3'd0) begin
      errors++; $display("FAIL reset_ptrs: wr=%0d fill=%0d rd=%0d drop=%0d, expected all 0",
                         dut.wr_ptr, dut.fill_ptr, dut.rd_ptr, dut.drop_cnt);
    end
    mem_q.delete();
    pc_en = 1'b0;
    repeat (2) @(posedge clk_tb);
    @(negedge clk_tb); reset = 1'b1;
    // A stale response after reset with nothing pending must be ignored.
    @(posedge clk_tb); #1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    @(posedge clk_tb); #1; imem_rsp_valid = 1'b0;
    @(negedge clk_tb);
    checks++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_reg !== 32'h0) begin
      errors++; $display("FAIL reset_stale_rsp: inst_valid=%b req_valid=%b pc_reg=%h, expected 0 0 00000000",
                         inst_valid, imem_req_valid, pc_reg);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_tb); #1;
      pc_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1; drive_mem(1'b1, 1'b0);
      @(negedge clk_tb);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * c)) begin
        errors++; $display("FAIL stream_req c%0d: valid=%b addr=%h, expected 1 %h", c, imem_req_valid, imem_req_addr, 32'(4 * c));
      end
      checks++;
      if (c >= 2) begin
        if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (c - 2)) || inst_data !== 32'h2231 + 32'(c - 2)) begin
          errors++; $display("FAIL stream_inst c%0d: valid=%b pc=%h data=%h, expected 1 %h %h", c, inst_valid, inst_pc,
                             inst_data, 32'(4 * (c - 2)), 32'h2231 + 32'(c - 2));
        end
      end else if (inst_valid !== 1'b0) begin
        errors++; $display("FAIL stream_inst_early c%0d: valid=%b, expected 0", c, inst_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int accepts;
    logic        ev;
    logic [31:0] ea, ep;
    accepts = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_tb); #1;
      pc_en = 1'b1; imem_req_ready = 1'b1; inst_ready = (c == 8); drive_mem(1'b1, 1'b0);
      @(negedge clk_tb);
      if (imem_req_valid && imem_req_ready) accepts++;
      ev = (c < 4) || (c == 9);
      ea = (c < 4) ? 32'(4 * c) : 32'h10;
      ep = (c < 4) ? 32'(4 * c) : ((c <= 9) ? 32'h10 : 32'h14);
      checks++;
      if (imem_req_valid !== ev || (ev && imem_req_addr !== ea) || pc_reg !== ep) begin
        errors++; $display("FAIL bp_req c%0d: valid=%b addr=%h pc=%h, expected %b %h %h", c, imem_req_valid,
                           imem_req_addr, pc_reg, ev, ea, ep);
      end
      if (c == 8 || c == 9) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (c - 8))) begin
          errors++; $display("FAIL bp_head c%0d: valid=%b pc=%h, expected 1 %h", c, inst_valid, inst_pc, 32'(4 * (c - 8)));
        end
      end
    end
    checks++;
    if (accepts != 5) begin errors++; $display("FAIL bp_accepts: got %0d, expected 5", accepts); end
  endtask

  task automatic test_stall();
    bit en;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(posedge clk_tb); #1;
      pc_en = (c < 4); imem_req_ready = 1'b1; inst_ready = 1'b1;
      en = (c >= 4) || (mem_q.size() > 0 && mem_q[0] < 32'h8);
      drive_mem(en, 1'b0);
      @(negedge clk_tb);
      if (c >= 4) begin
        checks++;
        if (imem_req_valid !== 1'b0 || pc_reg !== 32'h10) begin
          errors++; $display("FAIL stall_hold c%0d: req_valid=%b pc=%h, expected 0 00000010", c, imem_req_valid, pc_reg);
        end
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'(8 + 4 * (c - 5)) || inst_data !== 32'h2233 + 32'(c - 5)) begin
          errors++; $display("FAIL stall_deliver c%0d: valid=%b pc=%h data=%h, expected 1 %h %h", c, inst_valid, inst_pc,
                             inst_data, 32'(8 + 4 * (c - 5)), 32'h2233 + 32'(c - 5));
        end
      end
      if (c >= 7) begin
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL stall_drained c%0d: valid=%b, expected 0", c, inst_valid); end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_tb); #1;
      pc_en = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
      redirect_valid = (c == 2); redirect_pc = 32'h0000_5237;
      drive_mem(c >= 3, 1'b0);
      @(negedge clk_tb);
      if (c == 2) begin
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
          errors++; $display("FAIL redir_cycle: req_valid=%b inst_valid=%b, expected 0 0", imem_req_valid, inst_valid);
        end
      end
      if (c == 3) begin
        checks++;
        if (dut.drop_cnt !== 3'd2) begin errors++; $display("FAIL redir_drop_cnt: got %0d, expected 2", dut.drop_cnt); end
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (imem_req_valid !== 1'b0 || pc_reg !== 32'h5234 || inst_valid !== 1'b0) begin
          errors++; $display("FAIL redir_draining c%0d: req_valid=%b pc=%h inst_valid=%b, expected 0 00005234 0",
                             c, imem_req_valid, pc_reg, inst_valid);
        end
      end
      if (c == 5) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h5234) begin
          errors++; $display("FAIL redir_new_req: valid=%b addr=%h, expected 1 00005234", imem_req_valid, imem_req_addr);
        end
      end
      if (c == 6) begin
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_no_early: valid=%b, expected 0", inst_valid); end
      end
      if (c == 7) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h5234 || inst_data !== 32'h36BE) begin
          errors++; $display("FAIL redir_first_inst: valid=%b pc=%h data=%h, expected 1 00005234 000036be",
                             inst_valid, inst_pc, inst_data);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(posedge clk_tb); #1;
      pc_en = 1'b1; imem_req_ready = 1'b1; inst_ready = (c >= 3);
      redirect_valid = (c == 3); redirect_pc = 32'h0000_0100;
      if (c == 5) begin
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      end else begin
        drive_mem(c >= 2 && c != 6, 1'b0);
      end
      @(negedge clk_tb);
      if (c == 3) begin
        checks++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
          errors++; $display("FAIL simul_cycle: inst_valid=%b req_valid=%b, expected 0 0", inst_valid, imem_req_valid);
        end
      end
      if (c == 4) begin
        checks++;
        if (dut.drop_cnt !== 3'd1 || dut.wr_ptr !== 3'd0 || dut.rd_ptr !== 3'd0) begin
          errors++; $display("FAIL simul_state: drop=%0d wr=%0d rd=%0d, expected 1 0 0", dut.drop_cnt, dut.wr_ptr, dut.rd_ptr);
        end
        checks++;
        if (imem_req_valid !== 1'b0 || pc_reg !== 32'h100 || inst_valid !== 1'b0) begin
          errors++; $display("FAIL simul_after: req_valid=%b pc=%h inst_valid=%b, expected 0 00000100 0",
                             imem_req_valid, pc_reg, inst_valid);
        end
      end
      if (c == 5) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
          errors++; $display("FAIL simul_new_req: valid=%b addr=%h, expected 1 00000100", imem_req_valid, imem_req_addr);
        end
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL simul_spurious c%0d: valid=%b, expected 0", c, inst_valid); end
      end
      if (c == 8) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== 32'h2271) begin
          errors++; $display("FAIL simul_first_inst: valid=%b pc=%h data=%h, expected 1 00000100 00002271",
                             inst_valid, inst_pc, inst_data);
        end
      end
    end
  endtask

  task automatic test_random();
    ent_t        mq[$];
    logic [31:0] mpc;
    int          mdrop;
    int          unf;
    int          nd;
    bit          e_req, e_iv, fire, done;
    ent_t        ne;
    do_reset();
    mpc = 32'h0; mdrop = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk_tb); #1;
      pc_en          = ($urandom_range(0, 7) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom());
      if (mem_q.size() == 0 && $urandom_range(0, 7) == 0) begin
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'($urandom());
      end else begin
        drive_mem($urandom_range(0, 2) != 0, 1'b1);
      end
      e_req = pc_en && (mq.size() < DEPTH) && !redirect_valid && (mdrop == 0);
      e_iv  = (mq.size() > 0) && mq[0].filled && !redirect_valid;
      @(negedge clk_tb);
      checks++;
      if (imem_req_valid !== e_req) begin
        errors++; $display("FAIL rnd_req_valid n%0d: got %b, expected %b", n, imem_req_valid, e_req);
      end
      if (e_req) begin
        checks++;
        if (imem_req_addr !== mpc) begin errors++; $display("FAIL rnd_req_addr n%0d: got %h, expected %h", n, imem_req_addr, mpc); end
      end
      checks++;
      if (pc_reg !== mpc) begin errors++; $display("FAIL rnd_pc_reg n%0d: got %h, expected %h", n, pc_reg, mpc); end
      checks++;
      if (inst_valid !== e_iv) begin errors++; $display("FAIL rnd_inst_valid n%0d: got %b, expected %b", n, inst_valid, e_iv); end
      if (e_iv) begin
        checks++;
        if (inst_pc !== mq[0].pc || inst_data !== mq[0].data) begin
          errors++; $display("FAIL rnd_inst n%0d: pc=%h data=%h, expected %h %h", n, inst_pc, inst_data, mq[0].pc, mq[0].data);
        end
      end
      // Reference model update for the coming edge.
      fire = e_req && imem_req_ready;
      if (redirect_valid) begin
        unf = 0;
        foreach (mq[i]) if (!mq[i].filled) unf++;
        nd = unf + mdrop;
        if (imem_rsp_valid && (mdrop != 0 || unf != 0)) nd--;
        mdrop = nd;
        mq.delete();
        mpc = redirect_pc & ~32'h3;
      end else begin
        if (imem_rsp_valid) begin
          if (mdrop > 0) begin
            mdrop--;
          end else begin
            done = 1'b0;
            foreach (mq[i]) begin
              if (!done && !mq[i].filled) begin
                mq[i].data = imem_rsp_data; mq[i].filled = 1'b1; done = 1'b1;
              end
            end
          end
        end
        if (e_iv && inst_ready) void'(mq.pop_front());
        if (fire) begin
          ne.pc = mpc; ne.data = '0; ne.filled = 1'b0;
          mq.push_back(ne);
          mpc = mpc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_redirect();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
